lsu_ctrl: RTL and testbench
===========================

# lsu_ctrl

Load/store unit placed between the core datapath and the word-addressed data memory. It accepts one byte-addressed load or store request at a time from the execute stage and issues word accesses to `data_mem`. It handles RV32I LB/LH/LW/LBU/LHU/SB/SH/SW:
- sign/zero extension on loads;
- read-modify-write for sub-word stores;
- misalignment, range and illegal-funct3 errors.

Results return through a valid/ready response channel.

## Interface
Parameters:
- `MEM_WORDS`, 1024: depth of the attached data memory in 32-bit words. Legal byte addresses are 0 .. 4*MEM_WORDS-1.

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous, active-low
- `req_valid`  in  1  request present
- `req_ready`  out  1  unit can accept a request
- `req_we`  in  1  1 = store, 0 = load
- `req_funct3`  in  3  RV32I load/store funct3
- `req_addr`  in  32  byte address
- `req_wdata`  in  32  store data, right-aligned
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer takes response
- `rsp_rdata`  out  32  extended load data; 0 for stores and errors
- `rsp_err`  out  1  request rejected; no memory write occurred
- `mem_A`  out  32  word index: `req_addr >> 2`, upper bits zero
- `mem_WD`  out  32  write word
- `mem_we`  out  1  memory write enable
- `mem_RD`  in  32  combinational read word from memory

## Operation
- **States:** IDLE, RD, WR, RESP.
- **Handshake:**
  - `req_ready` = (state==IDLE).
  - A request is accepted on a clock edge with `req_valid & req_ready`.
  - At acceptance the unit registers the address, funct3, we and wdata.
- **Error check at acceptance.** Any one of the following makes the request an error:
  - misaligned: H/HU with `addr[0]`≠0, or W with `addr[1:0]`≠0;
  - out of range: `addr >= 4*MEM_WORDS`;
  - illegal funct3 for loads: 011, 110, 111;
  - illegal funct3 for stores: anything other than 000/001/010.

  Error requests go IDLE→RESP with `rsp_err`=1, `rsp_rdata`=0 and no memory access.
- **Load:** IDLE→RD→RESP.
  - In RD, `mem_A` is driven and `mem_RD` is captured at the end of the cycle.
  - Byte lane is selected by `addr[1:0]` and halfword lane by `addr[1]`.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- **SW:** IDLE→WR→RESP. In WR, `mem_we`=1 and `mem_WD`=wdata.
- **SB/SH:** IDLE→RD→WR→RESP.
  - The old word is captured in RD.
  - In WR, `mem_WD` = old word with the addressed byte/halfword replaced by `wdata[7:0]` / `wdata[15:0]`.
- **RESP:**
  - `rsp_valid`=1; outputs are held stable until `rsp_ready`.
  - On `rsp_valid & rsp_ready` → IDLE.
  - A new request is accepted no earlier than the following cycle (no same-cycle turnaround).
- `mem_we` is 1 only in WR and is decoded from the state register; `mem_WD` is 0 outside WR.
- `mem_A` holds the registered word index outside IDLE and is 0 in IDLE.

## Timing
- **Reset values** (immediate on `rst`=0, no clock needed):
  - state = IDLE;
  - `req_ready`=1 once `rst` deasserts, 0 while `rst`=0;
  - `rsp_valid`=0, `rsp_err`=0, `rsp_rdata`=0;
  - `mem_we`=0, `mem_WD`=0, `mem_A`=0.
- **Latency**, acceptance edge = cycle 0, until `rsp_valid` is first high:
  - error: cycle 1;
  - load and SW: cycle 2;
  - SB/SH: cycle 3.
- Memory write takes effect on the rising edge that ends WR.
- **Reset asserted mid-operation** (RD, WR or RESP): the operation is abandoned. No write occurs unless the WR-ending edge already happened. No response is produced.
- **Backpressure:** `rsp_rdata`/`rsp_err` are stable for as long as `rsp_ready`=0.
- The unit ignores `req_*` while not in IDLE.

## Structure
- **Package `lsu_pkg`:**
  - state enum (IDLE, RD, WR, RESP);
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
- **Sub-module `lsu_align`** (purely combinational):
  - load extract/extend: (word, addr[1:0], funct3) → rdata;
  - store merge: (old word, wdata, addr[1:0], funct3) → new word.
- `lsu_ctrl` holds the FSM and the registers, and instantiates `lsu_align`.

## Test plan
Memory is preloaded with word 8 = 0x00000123 and word 240 = 0x00000020.
- LW addr 0x20 → `rsp_rdata`=0x00000123, `rsp_err`=0, `rsp_valid` 2 cycles after acceptance; LW addr 0x3C0 → 0x00000020.
- SB addr 0x21 wdata 0x000000AB → `mem_we` pulses once in cycle 2, word 8 becomes 0x0000AB23; then LB 0x21 → 0xFFFFFFAB and LBU 0x21 → 0x000000AB.
- SH addr 0x22 wdata 0xFFFF8001 → word 8 becomes 0x8001AB23; LH 0x22 → 0xFFFF8001, LHU 0x22 → 0x00008001.
- LH addr 0x21, SW addr 0x22, LW addr 0x1000, load funct3=011 → each gives `rsp_err`=1, `rsp_rdata`=0 in cycle 1, and `mem_we` never asserts.
- Hold `rsp_ready`=0 for 5 cycles after LW 0x20 → `rsp_valid`/`rsp_rdata` stay stable and `req_ready` stays 0; release it → IDLE next cycle.
- Assert `rst`=0 while in RD of SB 0x20 → outputs go to reset values asynchronously, word 8 is unchanged, and no response is produced.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and decode helpers for the load/store unit.
package lsu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Flags an illegal funct3 or a misaligned access; range is checked by the caller.
  function automatic logic req_bad(input logic we, input logic [2:0] f3,
                                   input logic [1:0] lo);
    logic bad;
    bad = 1'b0;
    case (f3)
      F3_B:  bad = 1'b0;
      F3_H:  bad = lo[0];
      F3_W:  bad = |lo;
      F3_BU: bad = we;
      F3_HU: bad = we | lo[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extract/extend and sub-word store merge.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic [31:0] merged
);

  logic        [7:0]  byte_u;
  logic        [15:0] half_u;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;

  // Select the addressed lane and extend it according to funct3.
  always_comb begin
    byte_u = word[{lane, 3'b000} +: 8];
    half_u = lane[1] ? word[31:16] : word[15:0];
    byte_s = signed'(byte_u);
    half_s = signed'(half_u);
    case (funct3)
      F3_B:    rdata = 32'(byte_s);
      F3_H:    rdata = 32'(half_s);
      F3_BU:   rdata = 32'(byte_u);
      F3_HU:   rdata = 32'(half_u);
      default: rdata = word;
    endcase
  end

  // Replace the addressed byte/halfword of the old word; full words pass wdata.
  always_comb begin
    merged = word;
    case (funct3[1:0])
      2'b00: merged[{lane, 3'b000} +: 8] = wdata[7:0];
      2'b01: begin
        if (lane[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit: single outstanding byte-addressed request mapped onto a
// word-addressed memory, with read-modify-write for SB/SH.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_we,
  input  logic [31:0] mem_RD
);

  localparam logic [32:0] ADDR_LIM = 33'(4 * MEM_WORDS);

  lsu_state_t  state, state_n;
  logic        err_q;
  logic [31:0] addr_q;
  logic [2:0]  f3_q;
  logic        we_q;
  logic [31:0] wdata_q;
  logic [31:0] word_q;

  logic        accept;
  logic        req_err;
  logic [31:0] ld_data;
  logic [31:0] st_word;

  assign accept  = req_valid & (state == IDLE);
  assign req_err = req_bad(req_we, req_funct3, req_addr[1:0]) |
                   ({1'b0, req_addr} >= ADDR_LIM);

  lsu_align u_align (
    .word   (word_q),
    .lane   (addr_q[1:0]),
    .funct3 (f3_q),
    .wdata  (wdata_q),
    .rdata  (ld_data),
    .merged (st_word)
  );

  // Control state: FSM register and the latched error flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) err_q <= req_err;
    end
  end

  // Request fields latched at acceptance; memory word captured in RD.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q  <= req_addr;
      f3_q    <= req_funct3;
      we_q    <= req_we;
      wdata_q <= req_wdata;
    end
    if (state == RD) word_q <= mem_RD;
  end

  // Next-state and output decode; all outputs are gated by state so reset clears them.
  always_comb begin
    state_n   = state;
    req_ready = rst & (state == IDLE);
    rsp_valid = (state == RESP);
    rsp_err   = (state == RESP) & err_q;
    rsp_rdata = 32'h0;
    mem_we    = (state == WR);
    mem_WD    = 32'h0;
    mem_A     = (state == IDLE) ? 32'h0 : {2'b00, addr_q[31:2]};
    case (state)
      IDLE: begin
        if (accept) begin
          if (req_err)                          state_n = RESP;
          else if (req_we && req_funct3 == F3_W) state_n = WR;
          else                                  state_n = RD;
        end
      end
      RD:   state_n = we_q ? WR : RESP;
      WR: begin
        mem_WD  = st_word;
        state_n = RESP;
      end
      RESP: begin
        if (!err_q && !we_q) rsp_rdata = ld_data;
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed test-plan cases plus randomized traffic,
// checked against a byte-level reference model of the memory.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_we;
  logic [31:0] mem_RD;

  logic [31:0] mem [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic        init_mem = 1'b1;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu_ctrl #(.MEM_WORDS(1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_A      (mem_A),
    .mem_WD     (mem_WD),
    .mem_we     (mem_we),
    .mem_RD     (mem_RD)
  );

  // Attached data memory: combinational read, write on the edge ending WR.
  assign mem_RD = (mem_A < 32'd1024) ? mem[mem_A[9:0]] : 32'h0;

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
      mem[8]   <= 32'h00000123;
      mem[240] <= 32'h00000020;
    end else if (mem_we) begin
      mem[mem_A[9:0]] <= mem_WD;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // One transaction; entered and left at a negedge with the unit idle.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input int hold,
                        input logic use_lit, input logic [31:0] lit_rd, input logic lit_err);
    int          sz, sh, lat;
    logic        bad, wr;
    logic [31:0] word, mask, val, nw, exp_rd, exp_a;
    // Reference behaviour from the access rules.
    case (f3)
      3'd0, 3'd4: sz = 1;
      3'd1, 3'd5: sz = 2;
      3'd2:       sz = 4;
      default:    sz = 0;
    endcase
    bad = (sz == 0) || (we && f3 > 3'd2) || (addr >= 32'd4096);
    if (!bad && (addr % sz) != 0) bad = 1'b1;
    mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'h1 << (8 * sz)) - 32'h1);
    val = 32'h0;
    nw  = 32'h0;
    if (!bad) begin
      word = ref_mem[addr[11:2]];
      sh   = (addr % 4) * 8;
      if (!we) begin
        val = (word >> sh) & mask;
        if (f3 < 3'd4 && sz < 4 && val[8*sz-1]) val = val | ~mask;
      end else begin
        nw = (word & ~(mask << sh)) | ((wd & mask) << sh);
      end
    end
    exp_rd = (bad || we) ? 32'h0 : val;
    lat    = bad ? 1 : ((we && sz < 4) ? 3 : 2);
    wr     = !bad && we;
    exp_a  = addr >> 2;

    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    @(posedge clk);
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      chk("rsp_valid", 32'(rsp_valid), 32'(c == lat));
      chk("mem_we", 32'(mem_we), 32'(wr && c == lat - 1));
      chk("mem_WD", mem_WD, (wr && c == lat - 1) ? nw : 32'h0);
      chk("mem_A", mem_A, exp_a);
      chk("req_ready_busy", 32'(req_ready), 32'h0);
      if (c == lat) begin
        chk("rsp_err", 32'(rsp_err), 32'(bad));
        chk("rsp_rdata", rsp_rdata, exp_rd);
        if (use_lit) begin
          chk("lit_rdata", rsp_rdata, lit_rd);
          chk("lit_err", 32'(rsp_err), 32'(lit_err));
        end
        req_valid = 1'b0;
        rsp_ready = (hold == 0);
      end else begin
        req_valid  = $urandom_range(0, 1);
        req_we     = $urandom_range(0, 1);
        req_funct3 = $urandom_range(0, 7);
        req_addr   = $urandom_range(0, 255);
        req_wdata  = $urandom;
        rsp_ready  = $urandom_range(0, 1);
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'h1);
      chk("hold_rdata", rsp_rdata, exp_rd);
      chk("hold_err", 32'(rsp_err), 32'(bad));
      chk("hold_req_ready", 32'(req_ready), 32'h0);
      if (h == hold - 1) rsp_ready = 1'b1;
    end
    @(negedge clk);
    chk("idle_req_ready", 32'(req_ready), 32'h1);
    chk("idle_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("idle_mem_A", mem_A, 32'h0);
    chk("idle_mem_we", 32'(mem_we), 32'h0);
    if (wr) ref_mem[addr[11:2]] = nw;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    int          sel;

    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    ref_mem[8]   = 32'h00000123;
    ref_mem[240] = 32'h00000020;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_mem_A", mem_A, 32'h0);
    chk("rst_mem_WD", mem_WD, 32'h0);
    init_mem = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("post_rst_req_ready", 32'(req_ready), 32'h1);
    chk("post_rst_rsp_err", 32'(rsp_err), 32'h0);

    // Directed test-plan sequence.
    do_req(1'b0, 3'd2, 32'h20,  32'h0,        0, 1'b1, 32'h00000123, 1'b0);
    do_req(1'b0, 3'd2, 32'h3C0, 32'h0,        0, 1'b1, 32'h00000020, 1'b0);
    do_req(1'b1, 3'd0, 32'h21,  32'h000000AB, 0, 1'b1, 32'h0,        1'b0);
    do_req(1'b0, 3'd0, 32'h21,  32'h0,        0, 1'b1, 32'hFFFFFFAB, 1'b0);
    do_req(1'b0, 3'd4, 32'h21,  32'h0,        0, 1'b1, 32'h000000AB, 1'b0);
    do_req(1'b0, 3'd2, 32'h20,  32'h0,        0, 1'b1, 32'h0000AB23, 1'b0);
    do_req(1'b1, 3'd1, 32'h22,  32'hFFFF8001, 0, 1'b1, 32'h0,        1'b0);
    do_req(1'b0, 3'd1, 32'h22,  32'h0,        0, 1'b1, 32'hFFFF8001, 1'b0);
    do_req(1'b0, 3'd5, 32'h22,  32'h0,        0, 1'b1, 32'h00008001, 1'b0);
    do_req(1'b0, 3'd2, 32'h20,  32'h0,        0, 1'b1, 32'h8001AB23, 1'b0);
    do_req(1'b0, 3'd1, 32'h21,  32'h0,        0, 1'b1, 32'h0,        1'b1);
    do_req(1'b1, 3'd2, 32'h22,  32'h12345678, 0, 1'b1, 32'h0,        1'b1);
    do_req(1'b0, 3'd2, 32'h1000, 32'h0,       0, 1'b1, 32'h0,        1'b1);
    do_req(1'b0, 3'd3, 32'h20,  32'h0,        0, 1'b1, 32'h0,        1'b1);
    do_req(1'b0, 3'd2, 32'h20,  32'h0,        5, 1'b1, 32'h8001AB23, 1'b0);
    chk("word8_lit", mem[8], 32'h8001AB23);

    // Reset during RD of SB 0x20: abandoned, no write, no response.
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'd0;
    req_addr   = 32'h20;
    req_wdata  = 32'h00000055;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("rd_state_mem_A", mem_A, 32'h8);
    rst = 1'b0;
    #1;
    chk("arst_req_ready", 32'(req_ready), 32'h0);
    chk("arst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("arst_rsp_err", 32'(rsp_err), 32'h0);
    chk("arst_rsp_rdata", rsp_rdata, 32'h0);
    chk("arst_mem_we", 32'(mem_we), 32'h0);
    chk("arst_mem_WD", mem_WD, 32'h0);
    chk("arst_mem_A", mem_A, 32'h0);
    repeat (3) begin
      @(negedge clk);
      chk("arst_no_rsp", 32'(rsp_valid), 32'h0);
      chk("arst_no_we", 32'(mem_we), 32'h0);
    end
    rst = 1'b1;
    @(negedge clk);
    chk("arst_word8", mem[8], 32'h8001AB23);
    chk("arst_release_ready", 32'(req_ready), 32'h1);
    chk("arst_release_valid", 32'(rsp_valid), 32'h0);
    do_req(1'b0, 3'd2, 32'h20, 32'h0, 0, 1'b1, 32'h8001AB23, 1'b0);

    // Randomized traffic over a small hot region plus range edges.
    for (int n = 0; n < 400; n++) begin
      we  = $urandom_range(0, 1);
      f3  = $urandom_range(0, 7);
      sel = $urandom_range(0, 9);
      if (sel < 7)       addr = $urandom_range(0, 63);
      else if (sel == 7) addr = $urandom_range(4088, 4103);
      else if (sel == 8) addr = 32'h3C0 + $urandom_range(0, 63);
      else               addr = $urandom;
      do_req(we, f3, addr, $urandom, $urandom_range(0, 2), 1'b0, 32'h0, 1'b0);
    end

    for (int i = 0; i < 1024; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
